// File: rtl/noaa_mote_scheduler_if.sv
// Scheduler <-> shared NOAA statistics engine link.
// The scheduler drives reset, mode and sample; the engine answers with sample-taken, done and the result.
interface noaa_mote_scheduler_if #(
    parameter int DATA_W = 12
);
    logic              ENG_RESET;
    logic              ENG_MODE;
    logic [DATA_W-1:0] ENG_TN;
    logic              ENG_SAMPLE;
    logic              ENG_DONE;
    logic [DATA_W-1:0] ENG_AVG_SD;

    modport master (
        output ENG_RESET, ENG_MODE, ENG_TN,
        input  ENG_SAMPLE, ENG_DONE, ENG_AVG_SD
    );

    modport slave (
        input  ENG_RESET, ENG_MODE, ENG_TN,
        output ENG_SAMPLE, ENG_DONE, ENG_AVG_SD
    );
endinterface

// File: rtl/noaa_mote_scheduler.sv
// Round-robin arbiter sharing one NOAA AVG/SD engine among motes: grant 1 cycle after REQ, 2 engine-clear cycles,
// then run until ENG_DONE (result 1 cycle later), timeout or REQ drop; the mote holds REQ and is paced by SAMPLE_ACK.
module noaa_mote_scheduler #(
    parameter int NUM_MOTES = 4,
    parameter int DATA_W    = 12,
    parameter int TIMEOUT   = 255
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_MOTES-1:0]        REQ,
    input  logic [NUM_MOTES-1:0]        MODE_IN,
    input  logic [NUM_MOTES*DATA_W-1:0] TN_IN,
    output logic [NUM_MOTES-1:0]        GNT,
    output logic [NUM_MOTES-1:0]        SAMPLE_ACK,
    output logic [DATA_W-1:0]           RESULT,
    output logic [NUM_MOTES-1:0]        RESULT_VALID,
    output logic [NUM_MOTES-1:0]        ERR,
    output logic                        BUSY,
    noaa_mote_scheduler_if.master       eng
);
    localparam int IDX_W = (NUM_MOTES > 1) ? $clog2(NUM_MOTES) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FINISH} state_t;

    state_t               state_q, state_d;
    logic [NUM_MOTES-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 mode_q, mode_d;
    logic                 clr_q, clr_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic [NUM_MOTES-1:0] err_q, err_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 req_g;
    logic                 timeout;

    assign req_g   = REQ[gidx_q];
    assign timeout = (wdog_q == WD_W'(TIMEOUT));

    // Scan starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MOTES; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_MOTES);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (!req_g)     state_d = S_IDLE;
                else if (clr_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (!req_g)            state_d = S_IDLE;
                else if (eng.ENG_DONE) state_d = S_FINISH;
                else if (timeout)      state_d = S_IDLE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        last_d   = last_q;
        mode_d   = mode_q;
        clr_d    = 1'b0;
        wdog_d   = '0;
        result_d = result_q;
        err_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d  = NUM_MOTES'(1) << win_idx;
                    gidx_d = win_idx;
                    last_d = win_idx;
                    mode_d = MODE_IN[win_idx];
                end
            end
            S_CLEAR: clr_d = ~clr_q;
            S_RUN: begin
                wdog_d = eng.ENG_SAMPLE ? '0 : wdog_q + 1'b1;
                if (req_g && eng.ENG_DONE)               result_d = eng.ENG_AVG_SD;
                if (req_g && !eng.ENG_DONE && timeout) err_d    = gnt_q;
            end
            default: ;
        endcase
        if (state_d == S_IDLE) gnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            gnt_q    <= '0;
            gidx_q   <= '0;
            last_q   <= IDX_W'(NUM_MOTES - 1);
            mode_q   <= 1'b0;
            clr_q    <= 1'b0;
            wdog_q   <= '0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            clr_q    <= clr_d;
            wdog_q   <= wdog_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        GNT           = gnt_q;
        RESULT        = result_q;
        ERR           = err_q;
        BUSY          = (state_q != S_IDLE);
        SAMPLE_ACK    = '0;
        RESULT_VALID  = '0;
        eng.ENG_RESET = 1'b1;
        eng.ENG_MODE  = 1'b0;
        eng.ENG_TN    = '0;
        case (state_q)
            S_CLEAR: eng.ENG_MODE = mode_q;
            S_RUN: begin
                eng.ENG_RESET = 1'b0;
                eng.ENG_MODE  = mode_q;
                eng.ENG_TN    = TN_IN[int'(gidx_q)*DATA_W +: DATA_W];
                SAMPLE_ACK    = gnt_q & {NUM_MOTES{eng.ENG_SAMPLE}};
            end
            S_FINISH: begin
                eng.ENG_RESET = 1'b0;
                eng.ENG_MODE  = mode_q;
                RESULT_VALID  = gnt_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_noaa_mote_scheduler.sv
// Directed bench for noaa_mote_scheduler: a per-cycle vector table for one job, then hand sequences
// for fairness, timeout, abort, mid-run reset and the done/timeout race.
module tb_noaa_mote_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, mode;
    logic [47:0] tn;
    logic [3:0]  gnt, ack, rv, err;
    logic [11:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    noaa_mote_scheduler_if #(.DATA_W(12)) eng_if ();

    noaa_mote_scheduler #(.NUM_MOTES(4), .DATA_W(12), .TIMEOUT(255)) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .REQ          (req),
        .MODE_IN      (mode),
        .TN_IN        (tn),
        .GNT          (gnt),
        .SAMPLE_ACK   (ack),
        .RESULT       (result),
        .RESULT_VALID (rv),
        .ERR          (err),
        .BUSY         (busy),
        .eng          (eng_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  mode;
        logic        smp;
        logic        done;
        logic [11:0] avg;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [3:0]  rv;
        logic [3:0]  err;
        logic        busy;
        logic        erst;
        logic        emode;
        logic [11:0] tn;
        logic [11:0] res;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [42:0] outs();
        return {gnt, ack, rv, err, busy, eng_if.ENG_RESET, eng_if.ENG_MODE, eng_if.ENG_TN, result};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a grant, then counts engine-clear cycles until RUN is reached.
    task automatic wait_run(output logic [3:0] g, output int nclr);
        int t;
        t = 0;
        while (gnt == 4'b0 && t < 50) begin
            tick();
            t++;
        end
        g = gnt;
        nclr = 0;
        while (eng_if.ENG_RESET && nclr < 10) begin
            tick();
            nclr++;
        end
    endtask

    task automatic serve(input int nsmp, input logic [11:0] val, output logic [3:0] g,
                         output int nclr, output logic [3:0] rvs, output logic [11:0] res);
        wait_run(g, nclr);
        for (int i = 0; i < nsmp; i++) begin
            eng_if.ENG_SAMPLE = 1'b1;
            tick();
        end
        eng_if.ENG_SAMPLE = 1'b0;
        eng_if.ENG_DONE   = 1'b1;
        eng_if.ENG_AVG_SD = val;
        tick();
        eng_if.ENG_DONE   = 1'b0;
        eng_if.ENG_AVG_SD = 12'h0;
        rvs = rv;
        res = result;
        tick();
    endtask

    localparam logic [42:0] RST_OUTS = {4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0};

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0]  g, rvs;
        logic [11:0] res;
        int          nclr, cnt;

        // Single job on mote 0, mode 0, 8 samples, result 0x123; MODE_IN flips after grant.
        vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000};
        vecs[1]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 12'h000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000};
        vecs[2]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 12'h000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000};
        vecs[3]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 12'h000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 12'h111, 12'h000};
        vecs[4]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 12'h000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 12'h111, 12'h000};
        for (int i = 5; i <= 11; i++)
            vecs[i] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 12'h000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 12'h111, 12'h000};
        vecs[12] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 12'h123, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 12'h111, 12'h000};
        vecs[13] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 12'h000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 12'h000, 12'h123};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 12'h000, 12'h123};

        rst_n = 1'b0;
        req = 4'b0;
        mode = 4'b0;
        tn = {12'h444, 12'h333, 12'h222, 12'h111};
        eng_if.ENG_SAMPLE = 1'b0;
        eng_if.ENG_DONE   = 1'b0;
        eng_if.ENG_AVG_SD = 12'h0;
        tick();
        tick();
        chk("reset_outputs", 64'(outs()), 64'(RST_OUTS));
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            req  = vecs[i].req;
            mode = vecs[i].mode;
            eng_if.ENG_SAMPLE = vecs[i].smp;
            eng_if.ENG_DONE   = vecs[i].done;
            eng_if.ENG_AVG_SD = vecs[i].avg;
            #3;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].gnt, vecs[i].ack, vecs[i].rv, vecs[i].err, vecs[i].busy,
                     vecs[i].erst, vecs[i].emode, vecs[i].tn, vecs[i].res}));
            tick();
        end
        eng_if.ENG_SAMPLE = 1'b0;
        eng_if.ENG_DONE   = 1'b0;

        // Fresh pointer, then all four motes requesting continuously.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            serve(2, 12'h100 + 12'(j), g, nclr, rvs, res);
            chk($sformatf("fair_gnt%0d", j), 64'(g), 64'(4'b0001 << (j % 4)));
            chk($sformatf("fair_rv%0d", j), 64'(rvs), 64'(4'b0001 << (j % 4)));
            chk($sformatf("fair_res%0d", j), 64'(res), 64'(12'h100 + 12'(j)));
            if (j == 0) chk("fair_clear_cycles", 64'(nclr), 64'(2));
        end

        // Timeout on mote 2 with mote 3 also waiting.
        req = 4'b1100;
        wait_run(g, nclr);
        chk("to_gnt", 64'(g), 64'(4'b0100));
        eng_if.ENG_SAMPLE = 1'b1;
        tick();
        eng_if.ENG_SAMPLE = 1'b0;
        cnt = 0;
        while (err == 4'b0 && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("to_cycles", 64'(cnt), 64'(256));
        chk("to_err", 64'(err), 64'(4'b0100));
        chk("to_gnt_idle", 64'(gnt), 64'(4'b0000));
        chk("to_no_rv", 64'(rv), 64'(4'b0000));
        tick();
        chk("to_next_gnt", 64'(gnt), 64'(4'b1000));
        chk("to_err_1cyc", 64'(err), 64'(4'b0000));
        req = 4'b0000;
        tick();
        chk("clr_abort", 64'({gnt, busy, err}), 64'({4'b0, 1'b0, 4'b0}));

        // Abort: mote 1 drops REQ in RUN.
        req = 4'b0010;
        wait_run(g, nclr);
        chk("ab_gnt", 64'(g), 64'(4'b0010));
        eng_if.ENG_SAMPLE = 1'b1;
        tick();
        tick();
        eng_if.ENG_SAMPLE = 1'b0;
        req = 4'b0000;
        tick();
        chk("ab_idle", 64'({gnt, busy, eng_if.ENG_RESET, rv, err}), 64'({4'b0, 1'b0, 1'b1, 4'b0, 4'b0}));
        tick();
        chk("ab_quiet", 64'({rv, err}), 64'(8'h00));

        // Reset mid-RUN after 5 samples, then a fresh job on mote 1.
        req = 4'b0001;
        wait_run(g, nclr);
        chk("mr_gnt", 64'(g), 64'(4'b0001));
        eng_if.ENG_SAMPLE = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        eng_if.ENG_SAMPLE = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mr_reset_outputs", 64'(outs()), 64'(RST_OUTS));
        rst_n = 1'b1;
        req = 4'b0010;
        serve(3, 12'h5A5, g, nclr, rvs, res);
        chk("mr_gnt2", 64'(g), 64'(4'b0010));
        chk("mr_clear_cycles", 64'(nclr), 64'(2));
        chk("mr_rv", 64'(rvs), 64'(4'b0010));
        chk("mr_res", 64'(res), 64'(12'h5A5));
        req = 4'b0000;
        tick();

        // ENG_DONE in the same cycle the watchdog expires; MODE_IN flipped mid-run.
        req = 4'b0100;
        mode = 4'b0100;
        wait_run(g, nclr);
        chk("race_gnt", 64'(g), 64'(4'b0100));
        mode = 4'b0000;
        for (int i = 0; i < 255; i++) tick();
        chk("race_mode_mid", 64'(eng_if.ENG_MODE), 64'(1));
        chk("race_no_err_yet", 64'({busy, err}), 64'({1'b1, 4'b0}));
        eng_if.ENG_DONE   = 1'b1;
        eng_if.ENG_AVG_SD = 12'h3C3;
        tick();
        eng_if.ENG_DONE   = 1'b0;
        eng_if.ENG_AVG_SD = 12'h0;
        chk("race_rv", 64'(rv), 64'(4'b0100));
        chk("race_err", 64'(err), 64'(4'b0000));
        chk("race_res", 64'(result), 64'(12'h3C3));
        chk("race_mode", 64'(eng_if.ENG_MODE), 64'(1));
        req = 4'b0000;
        tick();
        chk("race_after", 64'({rv, err, busy}), 64'({4'b0, 4'b0, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
